pw_requant_serializer: RTL and testbench

- Consumer end of the pointwise-conv output interface: accepts one 9-channel vector of signed 16-bit conv results per valid pulse, with no backpressure upstream.
- Buffers vectors in a small FIFO, applies ReLU, right-shift requantization and saturation, and emits one 8-bit channel per cycle with a valid/ready handshake toward pooling / the next layer.
- Tracks pixel position within a frame and flags the last channel of the last pixel.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/pw_requant_serializer_if.sv | 32 +++
 rtl/pw_requant_serializer_vec_fifo.sv | 44 ++++
 rtl/pw_requant_serializer.sv | 92 +++++++++
 tb/tb_pw_requant_serializer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants, types and the requant helper.
// Build option: define PW_SER_ROUND_EN for round-half-up before the shift.
package cnn_pkg;

   localparam int NUM_PW_CH = 9;

   typedef logic [3:0] ch_idx_t;

   typedef enum logic {
      ST_EMPTY,
      ST_SEND
   } ser_state_e;

   // ReLU, right shift, clamp to the positive range of out_w bits.
   // Done at 32 bits so any input width up to 31 cannot wrap.
   function automatic logic signed [31:0] requant(input logic signed [31:0] x,
                                                  input int shift,
                                                  input int out_w);
      logic signed [31:0] r;
      logic signed [31:0] q;
      logic signed [31:0] maxv;
      r = (x < 0) ? 32'sd0 : x;
`ifdef PW_SER_ROUND_EN
      if (shift > 0) r = r + (32'sd1 <<< (shift - 1));
`endif
      q    = r >>> shift;
      maxv = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      return (q > maxv) ? maxv : q;
   endfunction

endpackage

// File: rtl/pw_requant_serializer_if.sv
// rtl/pw_requant_serializer_if.sv - pointwise-conv input and serialized output bundle.
interface pw_requant_serializer_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int DEPTH = 4
);
   logic signed [IN_W-1:0]  conv1_in, conv2_in, conv3_in, conv4_in, conv5_in;
   logic signed [IN_W-1:0]  conv6_in, conv7_in, conv8_in, conv9_in;
   logic                    valid_in;
   logic signed [OUT_W-1:0] out_data;
   logic [3:0]              out_ch;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_last_pix;
   logic                    out_last_frame;
   logic [$clog2(DEPTH):0]  fifo_level;
   logic                    overflow;

   modport master (
      output conv1_in, conv2_in, conv3_in, conv4_in, conv5_in,
      output conv6_in, conv7_in, conv8_in, conv9_in, valid_in, out_ready,
      input  out_data, out_ch, out_valid, out_last_pix, out_last_frame,
      input  fifo_level, overflow
   );

   modport slave (
      input  conv1_in, conv2_in, conv3_in, conv4_in, conv5_in,
      input  conv6_in, conv7_in, conv8_in, conv9_in, valid_in, out_ready,
      output out_data, out_ch, out_valid, out_last_pix, out_last_frame,
      output fifo_level, overflow
   );
endinterface

// File: rtl/pw_requant_serializer_vec_fifo.sv
// rtl/pw_requant_serializer_vec_fifo.sv - synchronous vector FIFO; a push
// into a full FIFO is accepted only when a pop happens on the same edge.
module vec_fifo #(
   parameter  int W     = 144,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic          accept_o,
   output logic [AW:0]   level_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   level_q;
   logic          full, empty, pop_ok;

   assign full     = (level_q == (AW+1)'(DEPTH));
   assign empty    = (level_q == '0);
   assign pop_ok   = pop_i && !empty;
   assign accept_o = push_i && (!full || pop_ok);
   assign rdata_o  = mem_q[rd_q];
   assign level_o  = level_q;

   always_ff @(posedge clk) begin
      if (accept_o) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (accept_o) wr_q <= wr_q + 1'b1;
         if (pop_ok)   rd_q <= rd_q + 1'b1;
         level_q <= level_q + (AW+1)'(accept_o) - (AW+1)'(pop_ok);
      end
   end
endmodule

// File: rtl/pw_requant_serializer.sv
// rtl/pw_requant_serializer.sv - buffers 9-channel conv vectors and emits one
// requantized channel per handshake; rounding follows PW_SER_ROUND_EN in cnn_pkg.
module pw_requant_serializer
   import cnn_pkg::*;
#(
   parameter int IN_W             = 16,
   parameter int OUT_W            = 8,
   parameter int SHIFT            = 4,
   parameter int DEPTH            = 4,
   parameter int PIXELS_PER_FRAME = 676
) (
   input logic clk,
   input logic rst,
   pw_requant_serializer_if.slave bus
);
   localparam int      VW       = NUM_PW_CH * IN_W;
   localparam int      AW       = $clog2(DEPTH);
   localparam int      PW       = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
   localparam ch_idx_t CH_LAST  = ch_idx_t'(NUM_PW_CH - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS_PER_FRAME - 1);

   ser_state_e     state_q;
   ch_idx_t        ch_q;
   logic [PW-1:0]  pix_q;
   logic           ovf_q;

   logic [VW-1:0]  head;
   logic [AW:0]    level;
   logic           push_ok, hs, pop;
   logic signed [IN_W-1:0] lane [NUM_PW_CH];
   logic signed [31:0]     rq;
   logic                   unused_rq;

   assign hs  = (state_q == ST_SEND) && bus.out_ready;
   assign pop = hs && (ch_q == CH_LAST);

   vec_fifo #(.W(VW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (bus.valid_in),
      .pop_i    (pop),
      .wdata_i  ({bus.conv9_in, bus.conv8_in, bus.conv7_in, bus.conv6_in, bus.conv5_in,
                  bus.conv4_in, bus.conv3_in, bus.conv2_in, bus.conv1_in}),
      .rdata_o  (head),
      .accept_o (push_ok),
      .level_o  (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ch_q    <= '0;
         pix_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.valid_in && !push_ok) ovf_q <= 1'b1;
         case (state_q)
            ST_EMPTY: if (push_ok) state_q <= ST_SEND;
            ST_SEND: begin
               if (hs) begin
                  if (ch_q == CH_LAST) begin
                     ch_q  <= '0;
                     pix_q <= (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
                     // Last vector leaving with nothing arriving behind it.
                     if (level == (AW+1)'(1) && !push_ok) state_q <= ST_EMPTY;
                  end else begin
                     ch_q <= ch_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_PW_CH; k++) begin : g_lane
      assign lane[k] = head[k*IN_W +: IN_W];
   end

   always_comb begin
      rq = requant(32'(lane[ch_q]), SHIFT, OUT_W);
   end

   assign unused_rq          = ^rq[31:OUT_W];
   assign bus.out_valid      = (state_q == ST_SEND);
   assign bus.out_data       = bus.out_valid ? rq[OUT_W-1:0] : '0;
   assign bus.out_ch         = ch_q;
   assign bus.out_last_pix   = bus.out_valid && (ch_q == CH_LAST);
   assign bus.out_last_frame = bus.out_last_pix && (pix_q == PIX_LAST);
   assign bus.fifo_level     = level;
   assign bus.overflow       = ovf_q;
endmodule

// File: tb/tb_pw_requant_serializer.sv
// tb/tb_pw_requant_serializer.sv - scoreboard bench for pw_requant_serializer.
module tb_pw_requant_serializer;
   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int SHIFT = 4;
   localparam int DEPTH = 4;
   localparam int PPF   = 3;

   typedef struct {
      int d;
      int ch;
      int lp;
      int lf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pw_requant_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

   pw_requant_serializer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .PIXELS_PER_FRAME(PPF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   int   occ = 0, sent = 0, acc_pix = 0, lf_seen = 0;
   bit   ovf = 0;
   int   sv[9];

   task automatic chk(input string name, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   function automatic int mdl_rq(input int x);
      int r;
      r = (x < 0) ? 0 : x;
`ifdef PW_SER_ROUND_EN
      r = r + (1 << (SHIFT - 1));
`endif
      r = r >> SHIFT;
      return (r > (1 << (OUT_W - 1)) - 1) ? (1 << (OUT_W - 1)) - 1 : r;
   endfunction

   // Reference: vector queue occupancy, handshakes and frame position.
   always @(posedge clk) begin
      int  v[9];
      bit  hs, pop;
      if (rst) begin
         occ = 0; sent = 0; acc_pix = 0; ovf = 0;
         exp_q.delete();
      end else begin
         hs  = (occ > 0) && bus.out_ready;
         pop = hs && (sent == 8);
         if (hs) sent = pop ? 0 : sent + 1;
         if (bus.valid_in) begin
            if (occ < DEPTH || pop) begin
               v[0] = int'(bus.conv1_in); v[1] = int'(bus.conv2_in); v[2] = int'(bus.conv3_in);
               v[3] = int'(bus.conv4_in); v[4] = int'(bus.conv5_in); v[5] = int'(bus.conv6_in);
               v[6] = int'(bus.conv7_in); v[7] = int'(bus.conv8_in); v[8] = int'(bus.conv9_in);
               for (int k = 0; k < 9; k++)
                  exp_q.push_back('{mdl_rq(v[k]), k, int'(k == 8),
                                    int'(k == 8 && acc_pix == PPF - 1)});
               acc_pix = (acc_pix == PPF - 1) ? 0 : acc_pix + 1;
               occ++;
            end else begin
               ovf = 1;
            end
         end
         if (pop) occ--;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("out_valid", int'(bus.out_valid), int'(occ > 0));
         chk("fifo_level", int'(bus.fifo_level), occ);
         chk("overflow", int'(bus.overflow), int'(ovf));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: ch %0d data %0d, expected none",
                        bus.out_ch, bus.out_data);
            end else begin
               e = exp_q[0];
               chk("out_data", int'(bus.out_data), e.d);
               chk("out_ch", int'(bus.out_ch), e.ch);
               chk("out_last_pix", int'(bus.out_last_pix), e.lp);
               chk("out_last_frame", int'(bus.out_last_frame), e.lf);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  if (bus.out_last_frame) lf_seen++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vec();
      bus.conv1_in = 16'(sv[0]); bus.conv2_in = 16'(sv[1]); bus.conv3_in = 16'(sv[2]);
      bus.conv4_in = 16'(sv[3]); bus.conv5_in = 16'(sv[4]); bus.conv6_in = 16'(sv[5]);
      bus.conv7_in = 16'(sv[6]); bus.conv8_in = 16'(sv[7]); bus.conv9_in = 16'(sv[8]);
   endtask

   task automatic rand_vec();
      for (int k = 0; k < 9; k++)
         sv[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 2500)) - 300;
   endtask

   task automatic pulse();
      drive_vec();
      bus.valid_in = 1'b1;
      step();
      bus.valid_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int lf0;
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 9; k++) sv[k] = 0;
      drive_vec();

      repeat (2) step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_level", int'(bus.fifo_level), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_data", int'(bus.out_data), 0);
      chk("rst_ch", int'(bus.out_ch), 0);
      chk("rst_last_frame", int'(bus.out_last_frame), 0);
      step();

      // Directed single vector at full throughput.
      sv = '{1600, 4000, -5, 24, 0, 15, 2032, -32768, 16};
      bus.out_ready = 1'b1;
      pulse();
      repeat (12) step();
      chk("single_drained", exp_q.size(), 0);

      // Backpressure held at channel 3.
      rand_vec();
      pulse();
      repeat (3) step();
      bus.out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_ch", int'(bus.out_ch), 3);
         step();
      end
      bus.out_ready = 1'b1;
      repeat (10) step();
      chk("bp_drained", exp_q.size(), 0);

      // Overflow: five back-to-back pushes into a depth-4 FIFO.
      do_reset();
      bus.out_ready = 1'b0;
      rand_vec();
      drive_vec();
      bus.valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_vec();
         drive_vec();
         step();
      end
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("ovf_level", int'(bus.fifo_level), 4);
      chk("ovf_flag", int'(bus.overflow), 1);
      step();
      bus.out_ready = 1'b1;
      repeat (45) step();
      chk("ovf_drained", exp_q.size(), 0);
      chk("ovf_sticky", int'(bus.overflow), 1);
      do_reset();
      @(negedge clk);
      chk("ovf_cleared", int'(bus.overflow), 0);
      step();

      // Full FIFO accepts a push on the same edge as a pop.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_vec();
         pulse();
      end
      bus.out_ready = 1'b1;
      repeat (8) step();
      rand_vec();
      drive_vec();
      bus.valid_in = 1'b1;
      step();
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("fullpop_level", int'(bus.fifo_level), 4);
      chk("fullpop_overflow", int'(bus.overflow), 0);
      step();
      bus.out_ready = 1'b1;
      repeat (45) step();
      chk("fullpop_drained", exp_q.size(), 0);

      // Frame boundary with PIXELS_PER_FRAME = 3, then reset mid-vector.
      do_reset();
      lf0 = lf_seen;
      for (int i = 0; i < 4; i++) begin
         rand_vec();
         pulse();
         repeat (10) step();
      end
      chk("frame_last_count", lf_seen - lf0, 1);
      rand_vec();
      pulse();
      repeat (4) step();
      do_reset();
      @(negedge clk);
      chk("midrst_valid", int'(bus.out_valid), 0);
      chk("midrst_level", int'(bus.fifo_level), 0);
      step();

      // Random traffic with random backpressure.
      for (int c = 0; c < 600; c++) begin
         rand_vec();
         drive_vec();
         bus.valid_in  = ($urandom_range(0, 9) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.valid_in  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (60) step();
      chk("random_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
